// File: rtl/streamif_stall_monitor.sv
// streamif_stall_monitor: per-channel AXI4-Stream stall watchdog with sticky faults and first-fault capture.
// Define STALL_PEAK_EN to build per-channel peak stall-run registers and the rd_sel/rd_peak readout.
module streamif_stall_monitor #(
  parameter int NUM_CH = 12,
  parameter int CNT_W  = 16,
  parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [NUM_CH-1:0] ch_tvalid,
  input  logic [NUM_CH-1:0] ch_tready,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [CNT_W-1:0]  stall_threshold,
  input  logic              fault_clear,
  output logic [NUM_CH-1:0] stall_now,
  output logic [NUM_CH-1:0] fault_status,
  output logic              detect_fault,
  output logic              first_fault_vld,
  output logic [SEL_W-1:0]  first_fault_ch,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_peak
);
  logic [NUM_CH-1:0] w_stall;
  logic [NUM_CH-1:0] w_hit;
  logic [CNT_W-1:0]  w_nxt [NUM_CH];
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [SEL_W-1:0]  w_low;
  always_comb begin
    w_low = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_stall[i] = ch_tvalid[i] & ~ch_tready[i] & ~ch_mask[i];
      w_nxt[i]   = (&r_cnt[i]) ? r_cnt[i] : r_cnt[i] + 1'b1;
      w_hit[i]   = w_stall[i] & (|stall_threshold) & (w_nxt[i] >= stall_threshold);
    end
    for (int i = NUM_CH - 1; i >= 0; i--)
      w_low = w_hit[i] ? SEL_W'(i) : w_low;
  end
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst)
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    else
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= w_stall[i] ? w_nxt[i] : '0;
  // a hit in the same cycle as fault_clear wins, both for the flags and the first-fault capture
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst) begin
      stall_now       <= '0;
      fault_status    <= '0;
      detect_fault    <= 1'b0;
      first_fault_vld <= 1'b0;
      first_fault_ch  <= '0;
    end else begin
      stall_now    <= w_stall;
      fault_status <= (fault_status & ~{NUM_CH{fault_clear}}) | w_hit;
      detect_fault <= |fault_status;
      if ((|w_hit) && (!first_fault_vld || fault_clear)) begin
        first_fault_vld <= 1'b1;
        first_fault_ch  <= w_low;
      end else if (fault_clear)
        first_fault_vld <= 1'b0;
    end
`ifdef STALL_PEAK_EN
  logic [CNT_W-1:0] r_peak [NUM_CH];
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst)
      for (int i = 0; i < NUM_CH; i++) r_peak[i] <= '0;
    else
      for (int i = 0; i < NUM_CH; i++)
        r_peak[i] <= fault_clear ? (w_stall[i] ? w_nxt[i] : '0)
                   : (w_stall[i] && w_nxt[i] > r_peak[i]) ? w_nxt[i] : r_peak[i];
  always_ff @(posedge ap_clk or posedge ap_rst)
    if (ap_rst)
      rd_peak <= '0;
    else
      rd_peak <= (int'(rd_sel) < NUM_CH) ? r_peak[rd_sel] : '0;
`else
  logic w_unused_rd_sel;
  assign w_unused_rd_sel = ^rd_sel;
  assign rd_peak = '0;
`endif
endmodule

// File: tb/tb_streamif_stall_monitor.sv
// tb_streamif_stall_monitor: directed self-checking bench, a 16-bit and a saturating 4-bit counter instance.
module tb_streamif_stall_monitor;
  localparam int N = 12;
`ifdef STALL_PEAK_EN
  localparam bit PK = 1'b1;
`else
  localparam bit PK = 1'b0;
`endif
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  tv = '0;
  logic [N-1:0]  tr = '1;
  logic [N-1:0]  msk = '0;
  logic [15:0]   thr = '0;
  logic [3:0]    thr4 = '0;
  logic          clr = 1'b0;
  logic [3:0]    sel = '0;
  logic [N-1:0]  sn, fs, sn4, fs4;
  logic          df, fv, df4, fv4;
  logic [3:0]    fc, fc4;
  logic [15:0]   pk;
  logic [3:0]    pk4;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  streamif_stall_monitor #(.NUM_CH(N), .CNT_W(16)) u_dut (
    .ap_clk(clk), .ap_rst(rst), .ch_tvalid(tv), .ch_tready(tr), .ch_mask(msk),
    .stall_threshold(thr), .fault_clear(clr), .stall_now(sn), .fault_status(fs),
    .detect_fault(df), .first_fault_vld(fv), .first_fault_ch(fc), .rd_sel(sel), .rd_peak(pk));
  streamif_stall_monitor #(.NUM_CH(N), .CNT_W(4)) u_dut4 (
    .ap_clk(clk), .ap_rst(rst), .ch_tvalid(tv), .ch_tready(tr), .ch_mask(msk),
    .stall_threshold(thr4), .fault_clear(clr), .stall_now(sn4), .fault_status(fs4),
    .detect_fault(df4), .first_fault_vld(fv4), .first_fault_ch(fc4), .rd_sel(sel), .rd_peak(pk4));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [N-1:0] v);
    tv = v;
    tr = ~v;
  endtask
  task automatic pulse_clear();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask
  initial begin
    step(2);
    chk("rst_sn", sn, 0);
    chk("rst_fs", fs, 0);
    chk("rst_df", df, 0);
    chk("rst_fv", fv, 0);
    chk("rst_fc", fc, 0);
    chk("rst_pk", pk, 0);
    rst = 1'b0;
    // T=4, ch3 stalls from cycle 0
    thr = 16'd4;
    step();
    drive(12'h008);
    step();
    chk("t1_sn", sn, 12'h008);
    chk("t1_fs_c1", fs, 0);
    step(2);
    chk("t1_fs_c3", fs, 0);
    step();
    chk("t1_fs_c4", fs, 12'h008);
    chk("t1_df_c4", df, 0);
    chk("t1_fv", fv, 1);
    chk("t1_fc", fc, 3);
    drive('0);
    step();
    chk("t1_df_c5", df, 1);
    pulse_clear();
    chk("t1_fs_clr", fs, 0);
    chk("t1_fv_clr", fv, 0);
    chk("t1_df_lag", df, 1);
    step();
    chk("t1_df_fall", df, 0);
    // T=1 flags a single stall cycle
    thr = 16'd1;
    drive(12'h010);
    step();
    drive('0);
    chk("t1b_fs", fs, 12'h010);
    chk("t1b_fc", fc, 4);
    pulse_clear();
    step();
    chk("t1b_fs_clr", fs, 0);
    // T=4, ch5: 3 stall, 1 ready, 3 stall, idle -> no fault, peak 3
    thr = 16'd4;
    for (int k = 0; k < 8; k++) begin
      drive((k != 3 && k != 7) ? 12'h020 : 12'h000);
      step();
      chk("t2_sn", sn, (k != 3 && k != 7) ? 12'h020 : 12'h000);
      chk("t2_fs", fs, 0);
    end
    sel = 4'd5;
    step(2);
    chk("t2_pk", pk, PK ? 3 : 0);
    sel = 4'd13;
    step(2);
    chk("t2_pk_oor", pk, 0);
    // T=2, ch7 and ch2 together; clear while stalling -> set wins, ch2 recaptured
    thr = 16'd2;
    drive(12'h084);
    step();
    chk("t3_fs_c1", fs, 0);
    step();
    chk("t3_fs", fs, 12'h084);
    chk("t3_fc", fc, 2);
    pulse_clear();
    chk("t3_fs_setwins", fs, 12'h084);
    chk("t3_fv_recap", fv, 1);
    chk("t3_fc_recap", fc, 2);
    chk("t3_df", df, 1);
    drive('0);
    pulse_clear();
    step();
    chk("t3_fs_clr", fs, 0);
    chk("t3_df_clr", df, 0);
    chk("t3_fv_clr", fv, 0);
    // masked ch0 stalls 100 cycles with T=10, then unmasked with stall held
    msk = 12'h001;
    thr = 16'd10;
    drive(12'h001);
    step(100);
    chk("t4_fs_masked", fs, 0);
    chk("t4_sn_masked", sn, 0);
    msk = '0;
    step(9);
    chk("t4_fs_c9", fs, 0);
    step();
    chk("t4_fs_c10", fs, 12'h001);
    chk("t4_fc", fc, 0);
    drive('0);
    pulse_clear();
    // 4-bit counter: T=0 for 40 stall cycles, then T=15
    thr = '0;
    drive(12'h002);
    step(40);
    chk("t5_fs4_dis", fs4, 0);
    chk("t5_fs_dis", fs, 0);
    sel = 4'd1;
    step(2);
    chk("t5_pk4_sat", pk4, PK ? 15 : 0);
    thr4 = 4'd15;
    step();
    chk("t5_fs4", fs4, 12'h002);
    chk("t5_fc4", fc4, 1);
    drive('0);
    thr4 = '0;
    pulse_clear();
    // async reset mid-cycle with a live fault
    thr = 16'd4;
    sel = 4'd3;
    drive(12'h008);
    step(5);
    chk("t6_fs_pre", fs, 12'h008);
    #3 rst = 1'b1;
    #1;
    chk("t6_sn_rst", sn, 0);
    chk("t6_fs_rst", fs, 0);
    chk("t6_df_rst", df, 0);
    chk("t6_fv_rst", fv, 0);
    chk("t6_pk_rst", pk, 0);
    drive('0);
    step();
    rst = 1'b0;
    drive(12'h008);
    step(3);
    drive('0);
    step(2);
    chk("t6_fs_post", fs, 0);
    chk("t6_df_post", df, 0);
    chk("t6_fv_post", fv, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/streamif_stall_monitor.md
# streamif_stall_monitor

Parametrised stream-interface stall watchdog for chain-control adaptors. Samples TVALID/TREADY of NUM_CH AXI4-Stream links and counts consecutive stall cycles (valid high, ready low) per channel. Sets a sticky per-channel fault when a run reaches a programmable threshold, and records which channel faulted first. Raises a single aggregated detect_fault. Replaces fixed 12-bit stall vectors with a configurable channel count, threshold, mask and clear.

## Interface
Parameters:
- NUM_CH, 12, number of monitored stream links (1..32)
- CNT_W, 16, stall run-length counter width (4..32)
- SEL_W, $clog2(NUM_CH) (min 1), channel index width

Ports:
- ap_clk  in  1  single clock
- ap_rst  in  1  asynchronous, active-high reset
- ch_tvalid  in  NUM_CH  TVALID of each monitored link
- ch_tready  in  NUM_CH  TREADY of each monitored link
- ch_mask  in  NUM_CH  1 = channel ignored (counter held 0, no fault)
- stall_threshold  in  CNT_W  consecutive stall cycles that constitute a fault; 0 = monitor disabled
- fault_clear  in  1  single-cycle pulse, clears sticky fault state
- stall_now  out  NUM_CH  registered per-channel stall snapshot
- fault_status  out  NUM_CH  sticky per-channel fault flags
- detect_fault  out  1  registered OR of fault_status
- first_fault_vld  out  1  first-fault capture valid
- first_fault_ch  out  SEL_W  index of first channel to fault
- rd_sel  in  SEL_W  peak-readout channel select (STALL_PEAK_EN only)
- rd_peak  out  CNT_W  longest stall run of rd_sel channel (STALL_PEAK_EN only)

## Operation
- stall_i = ch_tvalid[i] & ~ch_tready[i] & ~ch_mask[i], evaluated every cycle.
- cnt_i: stall_i → min(cnt_i+1, 2^CNT_W−1) (saturating); else → 0.
- hit_i = stall_i & (threshold≠0) & (sat(cnt_i+1) ≥ stall_threshold).
- fault_status[i] set on hit_i; held until fault_clear. If fault_clear and hit_i occur in the same cycle, set wins.
- Counters keep running after a fault. Counters are not affected by fault_clear.
- first_fault: when first_fault_vld=0 and any hit_i occurs, capture the lowest-index hitting channel and set vld. Later hits are ignored until fault_clear. Clear and hit in the same cycle: the new hit is captured.
- Threshold or mask changes take effect the next cycle. Unmasking a channel starts its count from 0.
- Reset mid-run: all state is cleared asynchronously. Monitoring restarts from 0 after reset deasserts.

## Timing
- Reset values: stall_now=0, fault_status=0, detect_fault=0, first_fault_vld=0, first_fault_ch=0, rd_peak=0; all counters and peaks=0.
- stall_now: stall_i registered, 1-cycle latency.
- Threshold T, stall starting in cycle 0: cnt=T−1 after the edge ending cycle T−2. hit occurs in cycle T−1. fault_status is high from cycle T. detect_fault is high from cycle T+1.
- T=1 flags a single stall cycle.
- A run of T−1 stall cycles followed by one non-stall cycle resets the count; no fault.
- detect_fault falls 1 cycle after fault_status clears.
- No combinational path from any input to any output.

## Configuration
- STALL_PEAK_EN defined:
  - Per-channel peak_i = max(peak_i, sat(cnt_i+1)) on each stall cycle.
  - fault_clear resets peak_i to 0, except that the current-cycle value is applied in the same cycle.
  - rd_peak = peak[rd_sel] registered, 1-cycle latency.
  - rd_sel ≥ NUM_CH returns 0.
- STALL_PEAK_EN undefined: no peak registers are built; rd_sel is ignored; rd_peak is tied to 0.

## Test plan
- NUM_CH=12, T=4, ch3 valid=1 ready=0 for 4 cycles from cycle 0 → fault_status=0x008 at cycle 4, detect_fault=1 at cycle 5, first_fault_ch=3.
- T=4, ch5 stalls 3 cycles, 1 ready cycle, 3 stall cycles → no fault; stall_now toggles accordingly; with STALL_PEAK_EN, rd_sel=5 gives rd_peak=3.
- T=2, ch7 and ch2 both begin stalling in the same cycle → fault_status=0x084, first_fault_ch=2. Pulse fault_clear while both keep stalling → flags stay set (set wins); first_fault_ch=2 is recaptured.
- ch_mask[0]=1, ch0 stalls 100 cycles with T=10 → no fault. Unmask with the stall held → fault 10 cycles later.
- CNT_W=4, T=0, ch1 stalls 40 cycles → no fault; with STALL_PEAK_EN, rd_peak saturates at 15. Then set T=15 → fault on the next stall cycle.
- Assert ap_rst mid-run, asynchronously, between clock edges → all outputs are 0 immediately. After release, a 3-cycle stall with T=4 produces no fault.
